// File: rtl/spike_readout_pkg.sv
// -----------------------------------------------------------------------------
// spike_readout_pkg
// Shared definitions for the spike readout stage: FSM state encoding, beat
// geometry of the serialized spike stream and the beat/lane position of each
// output neuron inside that stream.
// -----------------------------------------------------------------------------
package spike_readout_pkg;

    localparam int N_NEURON_D = 16;                      // output neurons (classes)
    localparam int IO_WIDTH_D = 8;                       // spike bits per beat
    localparam int BEATS      = N_NEURON_D / IO_WIDTH_D; // beats per timestep
    localparam int CLASS_W    = $clog2(N_NEURON_D);      // neuron index width
    localparam int BEAT_W     = (BEATS > 1) ? $clog2(BEATS) : 1;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_ACCUM  = 2'd1,
        ST_ARGMAX = 2'd2
    } state_e;

    // Beat b carries neurons b*io_width .. b*io_width+io_width-1, lowest
    // neuron index in the LSB of the beat.
    function automatic int beat_of(input int neuron, input int io_width);
        return neuron / io_width;
    endfunction

    function automatic int lane_of(input int neuron, input int io_width);
        return neuron % io_width;
    endfunction

endpackage

// File: rtl/spike_readout_acc_bank.sv
// -----------------------------------------------------------------------------
// spike_acc_bank
// One saturating spike counter per output neuron.
//   clr      : clear every counter (highest priority)
//   load     : first beat of a frame; beat-0 neurons load their spike bit,
//              all other neurons clear
//   add_en   : add the spike bits of beat beat_sel to that beat's neurons
//   rd_addr  -> rd_cnt  : combinational host readback
//   cmp_addr -> cmp_cnt : combinational port for the argmax walk
//   cnt0               : neuron 0, seeds the argmax
// -----------------------------------------------------------------------------
module spike_acc_bank
    import spike_readout_pkg::*;
#(
    parameter int N_NEURON = N_NEURON_D,
    parameter int IO_WIDTH = IO_WIDTH_D,
    parameter int CNT_W    = 8
) (
    input  logic                CLK,
    input  logic                RSTB,
    input  logic                clr,
    input  logic                load,
    input  logic                add_en,
    input  logic [BEAT_W-1:0]   beat_sel,
    input  logic [IO_WIDTH-1:0] spike,
    input  logic [CLASS_W-1:0]  rd_addr,
    input  logic [CLASS_W-1:0]  cmp_addr,
    output logic [CNT_W-1:0]    rd_cnt,
    output logic [CNT_W-1:0]    cmp_cnt,
    output logic [CNT_W-1:0]    cnt0
);

    logic [CNT_W-1:0] cnt_q [N_NEURON];
    logic [CNT_W-1:0] cnt_d [N_NEURON];

    // NOTE: every path starts from the held value, so no latch is inferred.
    always_comb begin
        for (int n = 0; n < N_NEURON; n++) begin
            cnt_d[n] = cnt_q[n];
            if (clr) begin
                cnt_d[n] = '0;
            end else if (load) begin
                cnt_d[n] = (beat_of(n, IO_WIDTH) == 0) ?
                           CNT_W'(spike[lane_of(n, IO_WIDTH)]) : '0;
            end else if (add_en && (beat_of(n, IO_WIDTH) == int'(beat_sel)) &&
                         spike[lane_of(n, IO_WIDTH)] && (cnt_q[n] != '1)) begin
                // Saturate at all-ones instead of wrapping.
                cnt_d[n] = cnt_q[n] + CNT_W'(1);
            end
        end
    end

    // NOTE: the counter array is small flop storage that must read zero after
    // reset, so it is reset like any other register (not a RAM); state is
    // updated with non-blocking assignments only.
    always_ff @(posedge CLK or negedge RSTB) begin
        if (!RSTB) begin
            for (int n = 0; n < N_NEURON; n++) cnt_q[n] <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign rd_cnt  = cnt_q[rd_addr];
    assign cmp_cnt = cnt_q[cmp_addr];
    assign cnt0    = cnt_q[0];

endmodule

// File: rtl/spike_readout.sv
// -----------------------------------------------------------------------------
// spike_readout
// Terminal stage of the spiking network. Reassembles each timestep's neuron
// spikes from byte beats, counts spikes per neuron over a frame of T+1
// timesteps, then walks the counters to find the winning class.
//   CLK, RSTB          : clock, asynchronous active-low reset
//   CLR                : synchronous frame abort (keeps last result)
//   T                  : timesteps per frame minus 1, sampled on first beat
//   IN_VALID, IN_SPIKE : spike beat stream, no backpressure
//   BUSY               : frame accumulating or argmax running
//   DONE               : one-cycle pulse, CLASS/MAX_CNT/TIE updated
//   CLASS, MAX_CNT, TIE: winning neuron, its count, equal-count flag
//   ERR                : sticky, a beat arrived while argmax was running
//   RD_ADDR, RD_CNT    : combinational counter readback
// -----------------------------------------------------------------------------
module spike_readout
    import spike_readout_pkg::*;
#(
    parameter int IO_WIDTH = IO_WIDTH_D,
    parameter int N_NEURON = N_NEURON_D,
    parameter int CNT_W    = 8,
    parameter int T_WIDTH  = 5
) (
    input  logic                CLK,
    input  logic                RSTB,
    input  logic                CLR,
    input  logic [T_WIDTH-1:0]  T,
    input  logic                IN_VALID,
    input  logic [IO_WIDTH-1:0] IN_SPIKE,
    output logic                BUSY,
    output logic                DONE,
    output logic [CLASS_W-1:0]  CLASS,
    output logic [CNT_W-1:0]    MAX_CNT,
    output logic                TIE,
    output logic                ERR,
    input  logic [CLASS_W-1:0]  RD_ADDR,
    output logic [CNT_W-1:0]    RD_CNT
);

    localparam logic [CLASS_W-1:0] LAST_IDX  = CLASS_W'(N_NEURON - 1);
    localparam logic [BEAT_W-1:0]  LAST_BEAT = BEAT_W'(BEATS - 1);

    state_e               state_q, state_d;
    logic [BEAT_W-1:0]    beat_q, beat_d;
    logic [T_WIDTH-1:0]   step_q, step_d;
    logic [T_WIDTH-1:0]   t_lat_q, t_lat_d;
    logic [CLASS_W-1:0]   idx_q, idx_d;
    // Running argmax result, copied to the outputs only on DONE.
    logic [CNT_W-1:0]     wbest_q, wbest_d;
    logic [CLASS_W-1:0]   wclass_q, wclass_d;
    logic                 wtie_q, wtie_d;
    logic [CLASS_W-1:0]   class_q, class_d;
    logic [CNT_W-1:0]     max_q, max_d;
    logic                 tie_q, tie_d;
    logic                 err_q, err_d;
    logic                 done_q, done_d;
    logic                 busy_q, busy_d;

    logic                 bank_clr, bank_load, bank_add;
    logic [CNT_W-1:0]     cmp_cnt, cnt0;

    logic [CNT_W-1:0]     base_best, run_best;
    logic [CLASS_W-1:0]   base_class, run_class;
    logic                 base_tie, run_tie;

    spike_acc_bank #(
        .N_NEURON (N_NEURON),
        .IO_WIDTH (IO_WIDTH),
        .CNT_W    (CNT_W)
    ) u_bank (
        .CLK      (CLK),
        .RSTB     (RSTB),
        .clr      (bank_clr),
        .load     (bank_load),
        .add_en   (bank_add),
        .beat_sel (beat_q),
        .spike    (IN_SPIKE),
        .rd_addr  (RD_ADDR),
        .cmp_addr (idx_q),
        .rd_cnt   (RD_CNT),
        .cmp_cnt  (cmp_cnt),
        .cnt0     (cnt0)
    );

    // One argmax compare. The first compare (idx 1) seeds from neuron 0 read
    // live, so the final beat's update to the counters is already visible.
    always_comb begin
        base_best  = wbest_q;
        base_class = wclass_q;
        base_tie   = wtie_q;
        if (idx_q == CLASS_W'(1)) begin
            base_best  = cnt0;
            base_class = '0;
            base_tie   = 1'b0;
        end
        run_best  = base_best;
        run_class = base_class;
        run_tie   = base_tie;
        if (cmp_cnt > base_best) begin
            run_best  = cmp_cnt;
            run_class = idx_q;
            run_tie   = 1'b0;
        end else if (cmp_cnt == base_best) begin
            run_tie = 1'b1;   // strict '>' keeps the lowest index on ties
        end
    end

    always_comb begin
        state_d   = state_q;
        beat_d    = beat_q;
        step_d    = step_q;
        t_lat_d   = t_lat_q;
        idx_d     = idx_q;
        wbest_d   = wbest_q;
        wclass_d  = wclass_q;
        wtie_d    = wtie_q;
        class_d   = class_q;
        max_d     = max_q;
        tie_d     = tie_q;
        err_d     = err_q;
        done_d    = 1'b0;
        bank_clr  = 1'b0;
        bank_load = 1'b0;
        bank_add  = 1'b0;

        if (CLR) begin
            // Abort: a coincident beat is dropped, last result is kept.
            state_d  = ST_IDLE;
            beat_d   = '0;
            step_d   = '0;
            err_d    = 1'b0;
            bank_clr = 1'b1;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (IN_VALID) begin
                        state_d   = ST_ACCUM;
                        t_lat_d   = T;
                        bank_load = 1'b1;
                        beat_d    = BEAT_W'(1);
                        step_d    = '0;
                    end
                end
                ST_ACCUM: begin
                    if (IN_VALID) begin
                        bank_add = 1'b1;
                        if (beat_q == LAST_BEAT) begin
                            beat_d = '0;
                            if (step_q == t_lat_q) begin
                                state_d = ST_ARGMAX;
                                step_d  = '0;
                                idx_d   = CLASS_W'(1);
                            end else begin
                                step_d = step_q + T_WIDTH'(1);
                            end
                        end else begin
                            beat_d = beat_q + BEAT_W'(1);
                        end
                    end
                end
                ST_ARGMAX: begin
                    if (IN_VALID) err_d = 1'b1;   // beat dropped
                    wbest_d  = run_best;
                    wclass_d = run_class;
                    wtie_d   = run_tie;
                    if (idx_q == LAST_IDX) begin
                        state_d = ST_IDLE;
                        done_d  = 1'b1;
                        class_d = run_class;
                        max_d   = run_best;
                        tie_d   = run_tie;
                    end else begin
                        idx_d = idx_q + CLASS_W'(1);
                    end
                end
                default: state_d = ST_IDLE;
            endcase
        end

        busy_d = (state_d != ST_IDLE);
    end

    always_ff @(posedge CLK or negedge RSTB) begin
        if (!RSTB) begin
            state_q  <= ST_IDLE;
            beat_q   <= '0;
            step_q   <= '0;
            t_lat_q  <= '0;
            idx_q    <= '0;
            wbest_q  <= '0;
            wclass_q <= '0;
            wtie_q   <= 1'b0;
            class_q  <= '0;
            max_q    <= '0;
            tie_q    <= 1'b0;
            err_q    <= 1'b0;
            done_q   <= 1'b0;
            busy_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            beat_q   <= beat_d;
            step_q   <= step_d;
            t_lat_q  <= t_lat_d;
            idx_q    <= idx_d;
            wbest_q  <= wbest_d;
            wclass_q <= wclass_d;
            wtie_q   <= wtie_d;
            class_q  <= class_d;
            max_q    <= max_d;
            tie_q    <= tie_d;
            err_q    <= err_d;
            done_q   <= done_d;
            busy_q   <= busy_d;
        end
    end

    assign BUSY    = busy_q;
    assign DONE    = done_q;
    assign CLASS   = class_q;
    assign MAX_CNT = max_q;
    assign TIE     = tie_q;
    assign ERR     = err_q;

endmodule

// File: tb/tb_spike_readout.sv
// -----------------------------------------------------------------------------
// tb_spike_readout
// Directed bench for spike_readout. A frame-level model (beat count, spike
// totals, argmax by plain loop, fixed 16-cycle result latency) is compared to
// the DUT every cycle; directed literal checks pin the model. A second
// instance with 4-bit counters shares the stimulus for the saturation case.
// -----------------------------------------------------------------------------
module tb_spike_readout;

    logic       CLK = 1'b0;
    logic       RSTB;
    logic       CLR;
    logic [4:0] T;
    logic       IN_VALID;
    logic [7:0] IN_SPIKE;
    logic [3:0] RD_ADDR;

    logic       BUSY, DONE, TIE, ERR;
    logic [3:0] CLASS;
    logic [7:0] MAX_CNT, RD_CNT;

    logic       BUSY4, DONE4, TIE4, ERR4;
    logic [3:0] CLASS4;
    logic [3:0] MAX_CNT4, RD_CNT4;

    int n_checks = 0;
    int n_errors = 0;

    always #5 CLK = ~CLK;

    spike_readout dut (
        .CLK(CLK), .RSTB(RSTB), .CLR(CLR), .T(T),
        .IN_VALID(IN_VALID), .IN_SPIKE(IN_SPIKE),
        .BUSY(BUSY), .DONE(DONE), .CLASS(CLASS), .MAX_CNT(MAX_CNT),
        .TIE(TIE), .ERR(ERR), .RD_ADDR(RD_ADDR), .RD_CNT(RD_CNT)
    );

    spike_readout #(.CNT_W(4)) dut4 (
        .CLK(CLK), .RSTB(RSTB), .CLR(CLR), .T(T),
        .IN_VALID(IN_VALID), .IN_SPIKE(IN_SPIKE),
        .BUSY(BUSY4), .DONE(DONE4), .CLASS(CLASS4), .MAX_CNT(MAX_CNT4),
        .TIE(TIE4), .ERR(ERR4), .RD_ADDR(RD_ADDR), .RD_CNT(RD_CNT4)
    );

    task automatic check(input string name, input int act, input int exp);
        n_checks++;
        if (act != exp) begin
            n_errors++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    // ---------------- frame-level model (8-bit counters) ----------------
    localparam int SAT = 255;
    int mc [16];
    int m_mode;        // 0 idle, 1 collecting beats, 2 waiting for result
    int m_beats, m_tl, m_rem;
    int m_class, m_max;
    bit m_tie, m_done, m_err;

    always @(posedge CLK or negedge RSTB) begin
        if (!RSTB) begin
            foreach (mc[i]) mc[i] = 0;
            m_mode = 0; m_beats = 0; m_tl = 0; m_rem = 0;
            m_class = 0; m_max = 0; m_tie = 0; m_done = 0; m_err = 0;
        end else begin
            m_done = 0;
            if (CLR) begin
                m_mode = 0;
                foreach (mc[i]) mc[i] = 0;
                m_err = 0;
            end else if (m_mode == 2) begin
                if (IN_VALID) m_err = 1;
                m_rem--;
                if (m_rem == 0) begin
                    int best, who;
                    best = -1; who = 0;
                    for (int n = 0; n < 16; n++)
                        if (mc[n] > best) begin best = mc[n]; who = n; end
                    m_class = who;
                    m_max   = best;
                    m_tie   = 0;
                    for (int n = 0; n < 16; n++)
                        if (n != who && mc[n] == best) m_tie = 1;
                    m_mode = 0;
                    m_done = 1;
                end
            end else if (IN_VALID) begin
                if (m_mode == 0) begin
                    foreach (mc[i]) mc[i] = 0;
                    m_tl = int'(T);
                    m_beats = 0;
                    m_mode = 1;
                end
                for (int b = 0; b < 8; b++) begin
                    int n;
                    n = (m_beats % 2) * 8 + b;
                    if (IN_SPIKE[b] && mc[n] < SAT) mc[n]++;
                end
                m_beats++;
                if (m_beats == 2 * (m_tl + 1)) begin
                    m_mode = 2;
                    m_rem  = 15;
                end
            end
        end
    end

    always @(negedge CLK) begin
        if (RSTB) begin
            check("busy",    BUSY,    int'(m_mode != 0));
            check("done",    DONE,    m_done);
            check("err",     ERR,     m_err);
            check("class",   CLASS,   m_class);
            check("max_cnt", MAX_CNT, m_max);
            check("tie",     TIE,     m_tie);
            check("rd_cnt",  RD_CNT,  mc[RD_ADDR]);
        end
    end

    // ---------------- stimulus helpers ----------------
    task automatic tick(input int n);
        repeat (n) begin @(posedge CLK); #1; end
    endtask

    task automatic send(input logic [7:0] v);
        IN_VALID = 1'b1;
        IN_SPIKE = v;
        @(posedge CLK); #1;
        IN_VALID = 1'b0;
        IN_SPIKE = 8'h00;
    endtask

    // Called in the cycle after the last beat; returns the cycle index
    // (last-beat cycle = 0) in which DONE is seen, or 0 on timeout.
    task automatic wait_done(output int lat);
        int k;
        k = 1;
        while (!DONE && k < 40) begin
            @(posedge CLK); #1;
            k++;
        end
        lat = DONE ? k : 0;
        if (!DONE) check("done_timeout", 0, 1);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        int lat, sum;
        bit seen;
        RSTB = 1'b0; CLR = 1'b0; IN_VALID = 1'b0; IN_SPIKE = 8'h00;
        T = 5'd0; RD_ADDR = 4'd0;
        tick(3);
        check("rst_busy",  BUSY,    0);
        check("rst_done",  DONE,    0);
        check("rst_class", CLASS,   0);
        check("rst_max",   MAX_CNT, 0);
        check("rst_tie",   TIE,     0);
        check("rst_err",   ERR,     0);
        check("rst_rd",    RD_CNT,  0);
        RSTB = 1'b1;
        tick(2);

        // Single step, neuron 0 spikes once.
        T = 5'd0;
        send(8'h01); send(8'h00);
        wait_done(lat);
        check("t1_latency", lat, 16);
        check("t1_class", CLASS, 0);
        check("t1_max",   MAX_CNT, 1);
        check("t1_tie",   TIE, 0);
        tick(2);

        // Four steps, neuron 15 spikes every step.
        T = 5'd3;
        repeat (4) begin send(8'h00); send(8'h80); end
        wait_done(lat);
        check("t2_latency", lat, 16);
        check("t2_class", CLASS, 15);
        check("t2_max",   MAX_CNT, 4);
        check("t2_tie",   TIE, 0);
        RD_ADDR = 4'd15; #1;
        check("t2_rd15", RD_CNT, 4);
        RD_ADDR = 4'd0;  #1;
        check("t2_rd0",  RD_CNT, 0);
        tick(2);

        // Neurons 1 and 2 tie at 2; lowest index wins.
        T = 5'd1;
        repeat (2) begin send(8'h06); send(8'h00); end
        wait_done(lat);
        check("t3_class", CLASS, 1);
        check("t3_max",   MAX_CNT, 2);
        check("t3_tie",   TIE, 1);
        tick(2);

        // Abort after 3 beats; the beat coincident with CLR is discarded.
        T = 5'd3;
        send(8'h03); send(8'h00); send(8'h01);
        CLR = 1'b1; IN_VALID = 1'b1; IN_SPIKE = 8'hFF;
        @(posedge CLK); #1;
        CLR = 1'b0; IN_VALID = 1'b0; IN_SPIKE = 8'h00;
        check("clr_busy", BUSY, 0);
        seen = 1'b0;
        repeat (20) begin @(posedge CLK); #1; if (DONE) seen = 1'b1; end
        check("clr_no_done", seen, 0);
        sum = 0;
        for (int a = 0; a < 16; a++) begin
            RD_ADDR = 4'(a); #1;
            sum += int'(RD_CNT);
        end
        RD_ADDR = 4'd0;
        check("clr_rd_sum", sum, 0);
        check("clr_class_kept", CLASS, 1);
        check("clr_tie_kept",   TIE, 1);
        tick(1);

        // Beat during argmax: dropped, ERR set; beat in DONE cycle starts a frame.
        T = 5'd0;
        send(8'h02); send(8'h00);
        tick(3);
        send(8'hFF);
        check("err_set", ERR, 1);
        wait_done(lat);
        check("err_class", CLASS, 1);
        check("err_max",   MAX_CNT, 1);
        check("err_tie",   TIE, 0);
        check("err_busy_done_cycle", BUSY, 0);
        send(8'h00);
        check("newframe_busy", BUSY, 1);
        check("err_sticky", ERR, 1);
        CLR = 1'b1; tick(1); CLR = 1'b0;
        check("err_cleared", ERR, 0);
        check("err_clr_busy", BUSY, 0);
        tick(1);

        // 32 steps of all-ones: 4-bit instance saturates at 15.
        T = 5'd31;
        repeat (64) send(8'hFF);
        wait_done(lat);
        check("sat_latency", lat, 16);
        check("sat_class",  CLASS, 0);
        check("sat_max",    MAX_CNT, 32);
        check("sat_tie",    TIE, 1);
        check("sat4_class", CLASS4, 0);
        check("sat4_max",   MAX_CNT4, 15);
        check("sat4_tie",   TIE4, 1);
        RD_ADDR = 4'd9; #1;
        check("sat4_rd9", RD_CNT4, 15);
        RD_ADDR = 4'd0;
        tick(2);

        // Asynchronous reset in the middle of a frame.
        T = 5'd2;
        send(8'h01); send(8'h01);
        RSTB = 1'b0; #2;
        check("mid_rst_busy",  BUSY, 0);
        check("mid_rst_max",   MAX_CNT, 0);
        check("mid_rst_rd",    RD_CNT, 0);
        check("mid_rst4_max",  MAX_CNT4, 0);
        tick(2);
        RSTB = 1'b1;
        tick(2);
        check("post_rst_busy", BUSY, 0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/spike_readout.md
Name: spike_readout

Overview:
- Terminal stage placed directly downstream of the last layer's serialized output port (OUT_VALID/OUT_SPIKE byte stream).
- Reassembles each timestep's 16 neuron spikes from byte beats and keeps one saturating spike counter per neuron over a frame of T+1 timesteps.
- At frame end, runs a sequential argmax over the 16 counters and reports the winning class, its count and a tie flag to the host/test interface.

Parameters:
- IO_WIDTH, 8, beat width; must divide N_NEURON.
- N_NEURON, 16, output neurons (classes).
- CNT_W, 8, per-neuron counter width.
- T_WIDTH, 5, width of timestep-count config.

Ports:
- CLK  input  1  clock
- RSTB  input  1  asynchronous active-low reset
- CLR  input  1  synchronous frame abort/clear
- T  input  T_WIDTH  timesteps per frame minus 1; sampled on first beat of a frame
- IN_VALID  input  1  beat valid (from upstream OUT_VALID)
- IN_SPIKE  input  IO_WIDTH  spike beat (from upstream OUT_SPIKE)
- BUSY  output  1  high in ACCUM or ARGMAX
- DONE  output  1  one-cycle pulse: result valid
- CLASS  output  4  winning neuron index (log2 N_NEURON)
- MAX_CNT  output  CNT_W  winning count
- TIE  output  1  another neuron equals MAX_CNT
- ERR  output  1  sticky: beat arrived during ARGMAX
- RD_ADDR  input  4  counter readback select
- RD_CNT  output  CNT_W  combinational readback of counter[RD_ADDR]

Behaviour:
- Reset (RSTB low, async): state IDLE; all counters, beat/step counters, CLASS, MAX_CNT, TIE, ERR, DONE, BUSY = 0.
- Beat order: BEATS = N_NEURON/IO_WIDTH = 2. Beat 0 carries neurons 7:0, beat 1 carries neurons 15:8; LSB = lowest index. No backpressure; every IN_VALID is one beat.
- IDLE: on IN_VALID, go to ACCUM. Capture T into t_lat. Load beat-0 neuron counters with the spike bits; this load clears the previous frame. Beat-1 counters are cleared at the same time. beat_cnt=1, step_cnt=0.
- ACCUM: each IN_VALID adds the spike bit to the neurons selected by beat_cnt. Counters saturate at 2^CNT_W-1 with no wrap. beat_cnt wraps BEATS-1 -> 0, and step_cnt increments on that wrap.
- Frame end: the beat accepted with beat_cnt=BEATS-1 and step_cnt=t_lat goes to ARGMAX on the next cycle.
- ARGMAX: idx runs 1..15, one compare per cycle. best starts at counter[0], CLASS=0, TIE=0.
  - counter[idx] > best: take idx, clear TIE.
  - counter[idx] == best: set TIE.
  - Lowest index wins ties.
- Latency: if the last beat is accepted in cycle N, compares occur in N+1..N+15. DONE pulses in N+16 with CLASS/MAX_CNT/TIE valid, and the state returns to IDLE in that cycle.
- CLASS/MAX_CNT/TIE hold until the next DONE. Counters hold their values after DONE for readback until the next frame's first beat.
- IN_VALID during ARGMAX: beat dropped, ERR set (sticky until CLR or reset).
- IN_VALID in the DONE cycle (state already IDLE): accepted as the first beat of a new frame.
- CLR (highest priority over all other events, any state):
  - next state IDLE; counters, beat_cnt, step_cnt, ERR cleared; DONE suppressed.
  - CLASS/MAX_CNT/TIE retained.
  - A beat coincident with CLR is discarded.
- RSTB asserted mid-frame: immediate return to reset values.
- BUSY = (state==ACCUM)|(state==ARGMAX), registered from the state.

Decomposition:
- Shared package:
  - state encoding IDLE/ACCUM/ARGMAX;
  - BEATS = N_NEURON/IO_WIDTH;
  - CLASS_W = log2(N_NEURON);
  - beat-to-neuron mapping constant.
- Sub-module spike_acc_bank: N_NEURON saturating counters with load/add/clear and readback mux. The FSM and argmax stay in the top.

Test Plan:
- T=0, beats 0x01,0x00 -> DONE 16 cycles after the 2nd beat; CLASS=0, MAX_CNT=1, TIE=0.
- T=3, four steps each with beats 0x00,0x80 -> CLASS=15, MAX_CNT=4, TIE=0. RD_ADDR=15 reads 4 and RD_ADDR=0 reads 0.
- T=1, steps {0x06,0x00} twice -> neurons 1,2 both 2. CLASS=1, MAX_CNT=2, TIE=1.
- T=31, CNT_W=4 build, 0xFF every beat -> all counters saturate at 15, not 0. CLASS=0, TIE=1.
- Frame in progress, CLR pulsed after 3 beats -> BUSY drops next cycle, no DONE, RD_CNT all 0. Prior CLASS held.
- IN_VALID pulsed during ARGMAX -> ERR=1 with result unchanged. A beat in the DONE cycle starts a new frame with BUSY=1 next cycle. CLR clears ERR.
